clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_pkg.sv | 53 +++++
 rtl/btn_edge.sv | 30 +++
 rtl/clock_set_ctrl.sv | 125 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared mode encoding, BCD limits, blank masks and BCD helpers
// for the clock_set_ctrl MM:SS clock.
package clock_set_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSE   = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    localparam logic [3:0] MAX_TENS  = 4'd5;
    localparam logic [3:0] MAX_ONES  = 4'd9;
    localparam logic [3:0] BLANK_MIN = 4'b1100;
    localparam logic [3:0] BLANK_SEC = 4'b0011;

    // One two-digit BCD field (minutes or seconds), range 00..59.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    // Increment a 00..59 BCD pair, wrapping 59 -> 00.
    function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
        bcd_pair_t r;
        r = v;
        if (v.ones == MAX_ONES) begin
            r.ones = 4'd0;
            r.tens = (v.tens == MAX_TENS) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    // True when the pair is at 59, i.e. the next increment wraps.
    function automatic logic bcd_is_max(input bcd_pair_t v);
        return (v.tens == MAX_TENS) && (v.ones == MAX_ONES);
    endfunction

    // Mode sequence stepped by each mode-button press.
    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            RUN:     r = PAUSE;
            PAUSE:   r = SET_MIN;
            SET_MIN: r = SET_SEC;
            default: r = RUN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: synchronizes one raw button and emits a one-cycle registered
// press pulse on its rising edge. SYNC_STAGES must be at least 2.
module btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw level through the synchronizer and flag its 0->1 transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: presetting the chain and edge flop to 1 makes a button held through reset release look like "no edge".
            sync_q <= '1;
            prev_q <= 1'b1;
            press  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples its neighbour's pre-edge value; blocking would collapse the chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            prev_q <= sync_q[SYNC_STAGES-1];
            press  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: MM:SS BCD clock with RUN / PAUSE / SET_MIN / SET_SEC modes,
// stepped by a mode button and adjusted by an increment button.
// Optional macro CLOCK_SET_CTRL_BLINK_EN enables blinking of the digits being set;
// without it blank is tied to zero.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [1:0] mode,
    output logic [3:0] blank
);

    logic      mode_press;
    logic      inc_press;
    mode_t     state_q, state_d;
    bcd_pair_t sec_q, sec_d;
    bcd_pair_t min_q, min_d;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode_btn (
        .clock (clock),
        .reset (reset),
        .raw   (btn_mode),
        .press (mode_press)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc_btn (
        .clock (clock),
        .reset (reset),
        .raw   (btn_inc),
        .press (inc_press)
    );

    // Next mode and next digits, every action decided from the pre-edge mode.
    always_comb begin
        // NOTE: defaults first so no branch leaves a variable unassigned, which would infer a latch.
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        if (mode_press) begin
            state_d = next_mode(state_q);
        end
        case (state_q)
            RUN: begin
                if (tick) begin
                    sec_d = bcd_inc(sec_q);
                    if (bcd_is_max(sec_q)) begin
                        min_d = bcd_inc(min_q);
                    end
                end
            end
            SET_MIN: if (inc_press) min_d = bcd_inc(min_q);
            SET_SEC: if (inc_press) sec_d = bcd_inc(sec_q);
            default: ;
        endcase
    end

    // Mode and digit registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            sec_q   <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
        end
    end

    assign sec_ones = sec_q.ones;
    assign sec_tens = sec_q.tens;
    assign min_ones = min_q.ones;
    assign min_tens = min_q.tens;
    assign mode     = state_q;

`ifdef CLOCK_SET_CTRL_BLINK_EN
    logic       phase_q, phase_d;
    logic [3:0] blank_q, blank_d;
    logic       entering_set;

    assign entering_set = (state_d != state_q) && (state_d == SET_MIN || state_d == SET_SEC);

    // Blink phase toggles per tick while setting and restarts on entering a set mode.
    always_comb begin
        phase_d = phase_q;
        if (entering_set) begin
            phase_d = 1'b0;
        end else if (tick && (state_q == SET_MIN || state_q == SET_SEC)) begin
            phase_d = ~phase_q;
        end
        blank_d = '0;
        if (phase_d && state_d == SET_MIN) begin
            blank_d = BLANK_MIN;
        end else if (phase_d && state_d == SET_SEC) begin
            blank_d = BLANK_SEC;
        end
    end

    // Phase and blank registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
            blank_q <= '0;
        end else begin
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl. A driver issues one
// stimulus cycle at a time, advances a seconds/minutes reference model and queues
// the expected outputs; a monitor pops and compares on every falling edge.
module tb_clock_set_ctrl;

    localparam int S = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [1:0] mode;
    logic [3:0] blank;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;

    logic [21:0] exp_q[$];

    // Reference model state: plain integers.
    int m_min, m_sec, m_mode, m_phase;
    bit hist_m[$];
    bit hist_i[$];

    clock_set_ctrl #(.SYNC_STAGES(S)) dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .mode     (mode),
        .blank    (blank)
    );

    always #5 clock = ~clock;

    function automatic logic [21:0] dut_vec();
        return {min_tens, min_ones, sec_tens, sec_ones, mode, blank};
    endfunction

    function automatic logic [21:0] model_vec();
        logic [3:0] b;
        b = 4'b0000;
`ifdef CLOCK_SET_CTRL_BLINK_EN
        if (m_phase != 0 && m_mode == 2) b = 4'b1100;
        if (m_phase != 0 && m_mode == 3) b = 4'b0011;
`endif
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10), 2'(m_mode), b};
    endfunction

    // A press lands S+1 edges after the first sampled high level (reset counts as high).
    task automatic model_edge(input bit t, input bit bm, input bit bi, input bit r);
        bit pm, pi;
        int old_mode, total;
        if (r) begin
            m_min = 0; m_sec = 0; m_mode = 0; m_phase = 0;
            hist_m = {};
            hist_i = {};
            repeat (S + 2) begin
                hist_m.push_back(1'b1);
                hist_i.push_back(1'b1);
            end
        end else begin
            pm = !hist_m[0] && hist_m[1];
            pi = !hist_i[0] && hist_i[1];
            hist_m.push_back(bm); void'(hist_m.pop_front());
            hist_i.push_back(bi); void'(hist_i.pop_front());
            old_mode = m_mode;
            if (old_mode == 0 && t) begin
                total = (m_min * 60 + m_sec + 1) % 3600;
                m_min = total / 60;
                m_sec = total % 60;
            end
            if (old_mode == 2 && pi) m_min = (m_min + 1) % 60;
            if (old_mode == 3 && pi) m_sec = (m_sec + 1) % 60;
            if (pm) m_mode = (m_mode + 1) % 4;
            if (pm && m_mode >= 2) m_phase = 0;
            else if (t && old_mode >= 2) m_phase = 1 - m_phase;
        end
    endtask

    // One clock of stimulus: drive after the falling edge, queue the expectation at the rising edge.
    task automatic step(input bit t, input bit bm, input bit bi, input bit r);
        logic [21:0] e;
        @(negedge clock);
        #1;
        tick = t; btn_mode = bm; btn_inc = bi; reset = r;
        model_edge(t, bm, bi, r);
        e = model_vec();
        @(posedge clock);
        exp_q.push_back(e);
        #1;
        cycle++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press_mode();
        step(0, 1, 0, 0);
        repeat (S + 2) step(0, 0, 0, 0);
    endtask

    task automatic press_inc();
        step(0, 0, 1, 0);
        repeat (S + 2) step(0, 0, 0, 0);
    endtask

    // Navigate through the set modes to reach MM:SS, ending in final_mode.
    task automatic set_time(input int m, input int s, input int final_mode);
        int n;
        while (m_mode != 2) press_mode();
        n = (m - m_min + 60) % 60;
        repeat (n) press_inc();
        press_mode();
        n = (s - m_sec + 60) % 60;
        repeat (n) press_inc();
        while (m_mode != final_mode) press_mode();
    endtask

    // Monitor: compare every presented output against the queued expectation.
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (dut_vec() !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard cycle %0d: dut=%h expected=%h", cycle, dut_vec(), e);
                end
            end
        end
    end

    initial begin
        int  first_change, changes;
        logic [1:0] prev_mode;
        bit  t, bm, bi, r;

        // Reset with mode button held through release: no press may result.
        repeat (3) step(0, 1, 0, 1);
        check("reset time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("reset mode", mode, 2'd0);
        check("reset blank", blank, 4'b0000);
        repeat (8) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("held through reset mode", mode, 2'd0);

        // RUN counting with carries.
        set_time(0, 58, 0);
        check("preload 00:58", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0058);
        step(1, 0, 0, 0);
        check("tick to 00:59", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
        step(1, 0, 0, 0);
        check("tick to 01:00", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0100);
        set_time(59, 59, 0);
        step(1, 0, 0, 0);
        check("59:59 wraps", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

        // Held mode button: exactly one step, landing S+1 edges after first sample.
        first_change = -1;
        changes = 0;
        prev_mode = mode;
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 0, 0);
            if (mode !== prev_mode) begin
                changes++;
                if (first_change < 0) first_change = i;
            end
            prev_mode = mode;
        end
        step(0, 0, 0, 0);
        check("hold mode steps", changes, 1);
        check("hold mode latency", first_change, S + 1);
        check("hold mode result", mode, 2'd1);

        // PAUSE ignores ticks and increments.
        set_time(12, 34, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, i < 3, 0);
            step(0, 0, 0, 0);
        end
        repeat (S + 2) step(0, 0, 0, 0);
        check("pause time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h1234);
        check("pause mode", mode, 2'd1);

        // Set-mode wraps.
        set_time(59, 30, 2);
        press_inc();
        check("set_min wrap", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0030);
        set_time(0, 59, 3);
        press_inc();
        check("set_sec wrap", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("set_sec mode", mode, 2'd3);

        // Blink pattern after entering SET_MIN.
        press_mode();
        press_mode();
        press_mode();
        check("set_min entry blank", blank, 4'b0000);
`ifdef CLOCK_SET_CTRL_BLINK_EN
        step(1, 0, 0, 0); check("blink 1", blank, 4'b1100);
        step(1, 0, 0, 0); check("blink 2", blank, 4'b0000);
        step(1, 0, 0, 0); check("blink 3", blank, 4'b1100);
`else
        step(1, 0, 0, 0); check("blink 1", blank, 4'b0000);
        step(1, 0, 0, 0); check("blink 2", blank, 4'b0000);
        step(1, 0, 0, 0); check("blink 3", blank, 4'b0000);
`endif

        // Reset while an increment is in flight in SET_SEC.
        press_mode();
        repeat (3) press_inc();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("mid reset time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
        check("mid reset mode", mode, 2'd0);
        check("mid reset blank", blank, 4'b0000);
        repeat (S + 2) step(0, 0, 0, 0);
        check("no late increment", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

        // Tick and mode press on the same edge in RUN.
        set_time(0, 9, 0);
        step(0, 1, 0, 0);
        repeat (S) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("tick+mode time", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0010);
        check("tick+mode mode", mode, 2'd1);

        // Randomized traffic, checked by the scoreboard.
        bm = 0;
        bi = 0;
        for (int i = 0; i < 1500; i++) begin
            t = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bm = ~bm;
            if ($urandom_range(0, 7) == 0) bi = ~bi;
            r = ($urandom_range(0, 299) == 0);
            step(t, bm, bi, r);
        end

        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
